hazard3_reset_ctrl: RTL and testbench
=====================================

Name: hazard3_reset_ctrl

Overview:
- Parametrised reset controller between the debug module's reset request/done handshake and the resets of N harts plus the system.
- Replaces direct `done = rst_n_cpu` wiring: each channel has a sequencer that holds reset for a guaranteed minimum width.
- Each sequencer waits for feedback from the downstream reset synchroniser, resynchronised into this domain, before reporting done.
- Done is only reported on a fresh completion, so a stale "done" tail from an earlier reset can never satisfy a new request.

Parameters:
- N_HARTS, 1, number of hart reset channels (1..16).
- MIN_ASSERT_CYCLES, 4, minimum clk cycles a reset output is held low (>=1).
- SYNC_STAGES, 2, flop stages on each feedback input (>=2).

Ports:
- clk  in  1  clock; all logic is in this domain.
- rst  in  1  synchronous active-high reset.
- sys_reset_req  in  1  level request from DM for a system reset.
- sys_reset_done  out  1  system reset sequence complete.
- hart_reset_req  in  N_HARTS  per-hart level request from DM.
- hart_reset_done  out  N_HARTS  per-hart sequence complete.
- sys_rst_n_out  out  1  active-low reset to system logic and its synchroniser.
- hart_rst_n_out  out  N_HARTS  active-low reset to each hart's synchroniser.
- sys_rst_n_fb  in  1  async feedback: output of the system reset synchroniser.
- hart_rst_n_fb  in  N_HARTS  async feedback: output of each hart reset synchroniser.
- havereset  out  N_HARTS  sticky flag: hart has been reset (optional feature).
- havereset_clr  in  N_HARTS  clears havereset (optional feature).

Behaviour:
- Channels: N_HARTS+1 identical sequencers. Index N_HARTS is the system channel, driven by sys_reset_req and sys_rst_n_fb.
- Feedback: each fb input passes through SYNC_STAGES flops to give fb_s. fb_s resets to 0.
- States per channel:
  - IDLE: rst_n_out=1, done=0.
  - ASSERT: rst_n_out=0, done=0.
  - RELEASE: rst_n_out=1, done=0.
  - DONE: rst_n_out=1, done=1.
- Transitions:
  - IDLE->ASSERT when req=1.
  - ASSERT->RELEASE when cnt==MIN_ASSERT_CYCLES-1 and fb_s==0.
  - RELEASE->DONE when fb_s==1 and req==1.
  - RELEASE->IDLE when fb_s==1 and req==0.
  - DONE->IDLE when req==0.
- Counter: cleared on entry to ASSERT, increments each ASSERT cycle, saturates at MIN_ASSERT_CYCLES-1. Width is clog2(MIN_ASSERT_CYCLES)+1.
- Output timing: rst_n_out and done are flop outputs, updated on the same edge as the state. Req sampled high in IDLE at edge k gives rst_n_out=0 from k+1.
- Minimum low width: rst_n_out stays low at least MIN_ASSERT_CYCLES cycles, and until the feedback has been seen low.
- Req dropped mid-ASSERT/RELEASE: the sequence still completes with full minimum width, then returns to IDLE without a done pulse.
- Req re-asserted in DONE: no effect. A new sequence requires req to fall, then rise again.
- Global gating: hart_rst_n_out[i] = hart channel i rst_n AND system channel rst_n, registered. A system reset therefore resets every hart; hart done flags are unaffected.
- rst (including mid-operation): every channel goes to ASSERT with cnt=0 and fb_s=0. All rst_n_out=0, all done=0, havereset=all 1. After release, channels with req=0 finish RELEASE->IDLE, so no spurious done.
- Feedback stuck high: ASSERT never exits and done never rises. This is intentional; the DM's timeout handles it.

Optional Feature:
- Macro: HAZARD3_RESET_CTRL_HAVERESET_EN.
- Defined:
  - havereset[i] sets when hart channel i (or the system channel) enters ASSERT.
  - havereset[i] clears on havereset_clr[i].
  - Set wins over a clear in the same cycle.
  - Reset value is all 1.
- Undefined: havereset is tied to 0, havereset_clr is ignored, and no flops are generated.

Test Plan:
- Bring-up, N_HARTS=2, MIN=4, fb tied to rst_n_out through a 2-flop sync: after rst releases, hart_rst_n_out stays low >=4 cycles, rises, and all done stay 0 throughout.
- hart_reset_req[1] pulsed high at cycle 10 and held: hart_rst_n_out[1]=0 at cycle 11 for >=4 cycles, hart_reset_done[1]=1 after fb rises. Channel 0 is untouched. Done clears the cycle after req falls.
- sys_reset_req held: sys_rst_n_out and both hart_rst_n_out go low. sys_reset_done=1 on completion; hart_reset_done stays 0.
- hart_reset_req[0] held 1 cycle only: a full >=4-cycle low pulse occurs, and done never asserts.
- Feedback delayed 20 cycles: rst_n_out low for exactly ~22+ cycles, not 4. Done rises only after fb_s is high.
- With HAVERESET_EN: clr[0] gives havereset=2'b10. hart 0 reset sets bit 0. clr[0] and a new request in the same cycle leave bit 0 at 1.

Source files
------------

// File: rtl/hazard3_reset_ctrl.sv
// ----------------------------------------------------------------------------
// hazard3_reset_ctrl
//
// Reset controller that sits between the debug module's level-sensitive reset
// request/done handshake and the active-low resets of N_HARTS harts plus the
// system. Each of the N_HARTS+1 channels runs its own small sequencer:
//   IDLE -> ASSERT (hold reset low for at least MIN_ASSERT_CYCLES and until the
//   downstream synchroniser is seen low) -> RELEASE (wait for the synchroniser
//   to come back high) -> DONE (report completion while the request is held).
// Done is only ever reported for a sequence that completed while its request
// was still high, so a stale done can never answer a fresh request.
//
// Channel index N_HARTS is the system channel. A system reset also pulls every
// hart reset low (hart outputs are gated by the system channel), but it does
// not produce a hart done.
//
// Parameters:
//   N_HARTS           number of hart channels (1..16)
//   MIN_ASSERT_CYCLES minimum clk cycles a reset output is held low (>=1)
//   SYNC_STAGES       resynchroniser depth on each feedback input (>=2)
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   sys_reset_req/_done      system channel request (in) / completion (out)
//   hart_reset_req/_done     per-hart request (in) / completion (out)
//   sys_rst_n_out            active-low reset to system logic
//   hart_rst_n_out           active-low reset to each hart synchroniser
//   sys_rst_n_fb             async feedback from the system reset synchroniser
//   hart_rst_n_fb            async feedback from each hart reset synchroniser
//   havereset / havereset_clr sticky "hart has been reset" flags and clears
//
// Optional feature: define HAZARD3_RESET_CTRL_HAVERESET_EN to build the
// havereset flags. Without it havereset is tied low and havereset_clr is
// ignored.
// ----------------------------------------------------------------------------
module hazard3_reset_ctrl #(
    parameter int N_HARTS           = 1,
    parameter int MIN_ASSERT_CYCLES = 4,
    parameter int SYNC_STAGES       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sys_reset_req,
    output logic               sys_reset_done,
    input  logic [N_HARTS-1:0] hart_reset_req,
    output logic [N_HARTS-1:0] hart_reset_done,
    output logic               sys_rst_n_out,
    output logic [N_HARTS-1:0] hart_rst_n_out,
    input  logic               sys_rst_n_fb,
    input  logic [N_HARTS-1:0] hart_rst_n_fb,
    output logic [N_HARTS-1:0] havereset,
    input  logic [N_HARTS-1:0] havereset_clr
);

    localparam int N_CH   = N_HARTS + 1;
    localparam int SYS_CH = N_HARTS;
    localparam int CNT_W  = $clog2(MIN_ASSERT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic [N_CH-1:0] req_all;
    logic [N_CH-1:0] fb_all;
    logic [N_CH-1:0] chan_rst_n_d;
    logic [N_CH-1:0] chan_done_d;
    logic [N_CH-1:0] enter_assert;

    assign req_all = {sys_reset_req, hart_reset_req};
    assign fb_all  = {sys_rst_n_fb, hart_rst_n_fb};

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic                   fb_s;
            state_t                 state_q;
            state_t                 state_d;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;

            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], fb_all[gi]};
            end

            assign fb_s = sync_q[SYNC_STAGES-1];

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                unique case (state_q)
                    ST_IDLE: begin
                        if (req_all[gi]) begin
                            state_d = ST_ASSERT;
                            cnt_d   = '0;
                        end
                    end
                    ST_ASSERT: begin
                        if (cnt_q != CNT_LAST) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        // Both the minimum width and the synchroniser having
                        // actually gone low are needed before letting go.
                        if ((cnt_q == CNT_LAST) && !fb_s) begin
                            state_d = ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        // A request that dropped mid-sequence ends quietly.
                        if (fb_s) begin
                            state_d = req_all[gi] ? ST_DONE : ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        if (!req_all[gi]) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_ASSERT;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q  <= '0;
                    state_q <= ST_ASSERT;
                    cnt_q   <= '0;
                end else begin
                    sync_q  <= sync_d;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Outputs are registered from the next state so they move on the
            // same edge as the state itself.
            assign chan_rst_n_d[gi] = (state_d != ST_ASSERT);
            assign chan_done_d[gi]  = (state_d == ST_DONE);
            assign enter_assert[gi] = (state_d == ST_ASSERT) && (state_q != ST_ASSERT);
        end
    endgenerate

    logic               sys_rst_n_q;
    logic               sys_rst_n_d;
    logic [N_HARTS-1:0] hart_rst_n_q;
    logic [N_HARTS-1:0] hart_rst_n_d;
    logic [N_CH-1:0]    done_q;
    logic [N_CH-1:0]    done_d;

    always_comb begin
        sys_rst_n_d  = chan_rst_n_d[SYS_CH];
        // A system reset holds every hart in reset as well.
        hart_rst_n_d = chan_rst_n_d[N_HARTS-1:0] & {N_HARTS{chan_rst_n_d[SYS_CH]}};
        done_d       = chan_done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sys_rst_n_q  <= 1'b0;
            hart_rst_n_q <= '0;
            done_q       <= '0;
        end else begin
            sys_rst_n_q  <= sys_rst_n_d;
            hart_rst_n_q <= hart_rst_n_d;
            done_q       <= done_d;
        end
    end

    assign sys_rst_n_out   = sys_rst_n_q;
    assign hart_rst_n_out  = hart_rst_n_q;
    assign sys_reset_done  = done_q[SYS_CH];
    assign hart_reset_done = done_q[N_HARTS-1:0];

`ifdef HAZARD3_RESET_CTRL_HAVERESET_EN
    logic [N_HARTS-1:0] havereset_q;
    logic [N_HARTS-1:0] havereset_d;

    always_comb begin
        // Set takes priority over a simultaneous clear.
        havereset_d = (havereset_q & ~havereset_clr)
                    | enter_assert[N_HARTS-1:0]
                    | {N_HARTS{enter_assert[SYS_CH]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            havereset_q <= '1;
        end else begin
            havereset_q <= havereset_d;
        end
    end

    assign havereset = havereset_q;
`else
    logic unused_havereset;
    assign unused_havereset = ^{havereset_clr, enter_assert};
    assign havereset        = '0;
`endif

endmodule

// File: tb/tb_hazard3_reset_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard3_reset_ctrl
//
// Directed bench for hazard3_reset_ctrl with N_HARTS=2, MIN_ASSERT_CYCLES=4,
// SYNC_STAGES=2. Each reset output is looped back to its feedback input
// through a per-channel shift register whose length models the downstream
// synchroniser (2 cycles by default, lengthened for the slow-feedback case).
// Expected reset sequences are queued when stimulus is driven and retired
// when the corresponding reset output rises.
// ----------------------------------------------------------------------------
module tb_hazard3_reset_ctrl;

    localparam int N   = 2;
    localparam int MIN = 4;
    localparam int NC  = N + 1;

`ifdef HAZARD3_RESET_CTRL_HAVERESET_EN
    localparam bit HR_EN = 1'b1;
`else
    localparam bit HR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         sys_reset_req;
    logic         sys_reset_done;
    logic [N-1:0] hart_reset_req;
    logic [N-1:0] hart_reset_done;
    logic         sys_rst_n_out;
    logic [N-1:0] hart_rst_n_out;
    logic         sys_rst_n_fb;
    logic [N-1:0] hart_rst_n_fb;
    logic [N-1:0] havereset;
    logic [N-1:0] havereset_clr;

    hazard3_reset_ctrl #(
        .N_HARTS          (N),
        .MIN_ASSERT_CYCLES(MIN),
        .SYNC_STAGES      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sys_reset_req  (sys_reset_req),
        .sys_reset_done (sys_reset_done),
        .hart_reset_req (hart_reset_req),
        .hart_reset_done(hart_reset_done),
        .sys_rst_n_out  (sys_rst_n_out),
        .hart_rst_n_out (hart_rst_n_out),
        .sys_rst_n_fb   (sys_rst_n_fb),
        .hart_rst_n_fb  (hart_rst_n_fb),
        .havereset      (havereset),
        .havereset_clr  (havereset_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel views: index 0..N-1 harts, index N system.
    logic [NC-1:0] rn;
    logic [NC-1:0] dv;
    assign rn = {sys_rst_n_out, hart_rst_n_out};
    assign dv = {sys_reset_done, hart_reset_done};

    // Downstream synchroniser model.
    logic [31:0]   hist [NC];
    int            dly  [NC];
    logic [NC-1:0] fbv;

    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (rst) hist[c] <= '0;
            else     hist[c] <= {hist[c][30:0], rn[c]};
        end
    end

    always_comb begin
        fbv = '1;
        for (int c = 0; c < NC; c++) fbv[c] = hist[c][dly[c]-1];
    end
    assign hart_rst_n_fb = fbv[N-1:0];
    assign sys_rst_n_fb  = fbv[N];

    // Output monitor, sampled 2 time units after each rising edge.
    int   low_run    [NC];
    int   last_low   [NC];
    int   rises      [NC];
    int   done_rises [NC];
    logic done_prev  [NC];

    always @(posedge clk) begin
        #2;
        for (int c = 0; c < NC; c++) begin
            if (rst) begin
                // The final reset cycle is the first low cycle after release.
                low_run[c]    <= rn[c] ? 0 : 1;
                rises[c]      <= 0;
                done_rises[c] <= 0;
                done_prev[c]  <= 1'b0;
            end else begin
                if (!rn[c]) begin
                    low_run[c] <= low_run[c] + 1;
                end else if (low_run[c] != 0) begin
                    last_low[c] <= low_run[c];
                    rises[c]    <= rises[c] + 1;
                    low_run[c]  <= 0;
                end
                if (dv[c] && !done_prev[c]) done_rises[c] <= done_rises[c] + 1;
                done_prev[c] <= dv[c];
            end
        end
    end

    // Scoreboard of expected reset sequences.
    typedef struct packed {
        int id;
        int chan;
        int min_low;
        int max_low;
        int exp_done;
        int min_lat;
        int rise_base;
        int done_base;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push_exp(input int id, input int chan, input int min_low, input int max_low,
                            input int exp_done, input int min_lat);
        exp_t e;
        e.id        = id;
        e.chan      = chan;
        e.min_low   = min_low;
        e.max_low   = max_low;
        e.exp_done  = exp_done;
        e.min_lat   = min_lat;
        e.rise_base = rises[chan];
        e.done_base = done_rises[chan];
        sb.push_back(e);
    endtask

    // Retire the oldest expected sequence: wait for its reset to rise, check
    // the low width, then check whether done follows.
    task automatic complete();
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while ((rises[e.chan] == e.rise_base) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("seq%0d_ch%0d_rise", e.id, e.chan), 32'(rises[e.chan] != e.rise_base), 1);
        check_range($sformatf("seq%0d_ch%0d_low_width", e.id, e.chan),
                    last_low[e.chan], e.min_low, e.max_low);
        if (e.exp_done != 0) begin
            n = 0;
            while ((dv[e.chan] !== 1'b1) && (n < 300)) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("seq%0d_ch%0d_done", e.id, e.chan), 32'(dv[e.chan]), 1);
            check_range($sformatf("seq%0d_ch%0d_done_latency", e.id, e.chan), n, e.min_lat, 299);
        end else begin
            repeat (20) @(negedge clk);
            check($sformatf("seq%0d_ch%0d_no_done", e.id, e.chan),
                  32'(done_rises[e.chan]), 32'(e.done_base));
        end
    endtask

    int r0;
    int hd0;
    int hd1;

    initial begin
        for (int c = 0; c < NC; c++) dly[c] = 2;
        rst            = 1'b1;
        sys_reset_req  = 1'b0;
        hart_reset_req = '0;
        havereset_clr  = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_hart_rst_n", 32'(hart_rst_n_out), 0);
        check("rst_sys_rst_n", 32'(sys_rst_n_out), 0);
        check("rst_hart_done", 32'(hart_reset_done), 0);
        check("rst_sys_done", 32'(sys_reset_done), 0);
        check("rst_havereset", 32'(havereset), HR_EN ? 32'h3 : 32'h0);

        // Bring-up: every channel holds reset for the minimum, then idles.
        rst = 1'b0;
        for (int c = 0; c < NC; c++) push_exp(1, c, MIN, 1000, 0, 0);
        for (int c = 0; c < NC; c++) complete();

        // Hart 1 reset request held.
        repeat (10) @(negedge clk);
        r0 = rises[0];
        hart_reset_req[1] = 1'b1;
        push_exp(2, 1, MIN, 1000, 1, 2);
        @(negedge clk);
        check("h1_rst_n_low_next_cycle", 32'(hart_rst_n_out[1]), 0);
        check("h1_ch0_untouched", 32'(hart_rst_n_out[0]), 1);
        complete();
        check("h1_ch0_no_pulse", 32'(rises[0]), 32'(r0));
        check("h1_ch0_no_done", 32'(hart_reset_done[0]), 0);
        hart_reset_req[1] = 1'b0;
        @(negedge clk);
        check("h1_done_clears", 32'(hart_reset_done[1]), 0);

        // System reset request held: harts go down too but report no done.
        repeat (10) @(negedge clk);
        hd0 = done_rises[0];
        hd1 = done_rises[1];
        sys_reset_req = 1'b1;
        push_exp(3, N, MIN, 1000, 1, 2);
        @(negedge clk);
        check("sys_rst_n_low", 32'(sys_rst_n_out), 0);
        check("sys_gates_harts", 32'(hart_rst_n_out), 0);
        complete();
        check("sys_hart0_no_done", 32'(done_rises[0]), 32'(hd0));
        check("sys_hart1_no_done", 32'(done_rises[1]), 32'(hd1));
        check("sys_hart_done_low", 32'(hart_reset_done), 0);
        check("sys_harts_released", 32'(hart_rst_n_out), 3);
        sys_reset_req = 1'b0;
        @(negedge clk);
        check("sys_done_clears", 32'(sys_reset_done), 0);

        // One-cycle request: full-width pulse, no done.
        repeat (10) @(negedge clk);
        hart_reset_req[0] = 1'b1;
        push_exp(4, 0, MIN, 1000, 0, 0);
        @(negedge clk);
        hart_reset_req[0] = 1'b0;
        complete();

        // Slow feedback: width follows the feedback, done only after it.
        repeat (30) @(negedge clk);
        dly[0] = 20;
        hart_reset_req[0] = 1'b1;
        push_exp(5, 0, 22, 24, 1, 20);
        complete();
        hart_reset_req[0] = 1'b0;
        @(negedge clk);
        check("slow_done_clears", 32'(hart_reset_done[0]), 0);
        repeat (30) @(negedge clk);
        dly[0] = 2;

        // havereset flags.
        repeat (10) @(negedge clk);
        check("hr_after_sys", 32'(havereset), HR_EN ? 32'h3 : 32'h0);
        havereset_clr = 2'b01;
        @(negedge clk);
        havereset_clr = 2'b00;
        check("hr_clr0", 32'(havereset), HR_EN ? 32'h2 : 32'h0);
        hart_reset_req[0] = 1'b1;
        push_exp(6, 0, MIN, 1000, 1, 2);
        @(negedge clk);
        check("hr_set0", 32'(havereset), HR_EN ? 32'h3 : 32'h0);
        complete();
        hart_reset_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        havereset_clr = 2'b01;
        @(negedge clk);
        check("hr_clr0_again", 32'(havereset), HR_EN ? 32'h2 : 32'h0);
        hart_reset_req[0] = 1'b1;
        push_exp(7, 0, MIN, 1000, 1, 2);
        @(negedge clk);
        havereset_clr = 2'b00;
        check("hr_set_beats_clr", 32'(havereset), HR_EN ? 32'h3 : 32'h0);
        complete();
        hart_reset_req[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("final_idle_done", 32'(dv), 0);
        check("final_idle_rst_n", 32'(rn), 7);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
